// File: rtl/decoder_pkg.sv
// Shared types and decode helper for the 2-to-4 one-hot decoder.
package decoder_pkg;

   localparam int SEL_W = 2;
   localparam int OUT_N = 4;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_N-1:0] dec_t;

   // Active-high one-hot code for sel; all zero when en is low.
   function automatic dec_t onehot_dec(input sel_t sel, input logic en);
      dec_t d;
      d = '0;
      if (en) begin
         d[sel] = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/decoder_2to4_hitcnt.sv
// Single saturating hit counter with synchronous clear and async reset.
// Clear wins over a simultaneous increment; the count never wraps.
module decoder_2to4_hitcnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_sat;

   assign w_sat = (r_cnt == {CNT_W{1'b1}});

   // Count hits, holding at full scale; clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable and selectable polarity.
// Optional per-line hit counters are compiled in with DECODER_2TO4_HITCNT_EN;
// without it the hit_clr/hit_cnt ports and all counter logic are absent.
module decoder_2to4
   import decoder_pkg::*;
#(
   parameter bit OUT_ACTIVE_LOW = 1'b0,
   parameter int CNT_W          = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [SEL_W-1:0]   inp,
   output logic [OUT_N-1:0]   outp,
   output logic               out_valid
`ifdef DECODER_2TO4_HITCNT_EN
   ,
   input  logic               hit_clr,
   output logic [OUT_N*CNT_W-1:0] hit_cnt
`endif
);

   // Deasserted level of every output line for the chosen polarity.
   localparam dec_t IDLE_OUT = {OUT_N{OUT_ACTIVE_LOW}};

   if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_chk
      $error("decoder_2to4: CNT_W must be in 1..32");
   end

   dec_t w_dec;
   dec_t r_outp;
   logic r_valid;

   assign w_dec = onehot_dec(inp, enable);

   // Register the decoded code (polarity applied) and the enable as valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outp  <= IDLE_OUT;
         r_valid <= 1'b0;
      end else begin
         r_outp  <= OUT_ACTIVE_LOW ? ~w_dec : w_dec;
         r_valid <= enable;
      end
   end

   assign outp      = r_outp;
   assign out_valid = r_valid;

`ifdef DECODER_2TO4_HITCNT_EN
   // One counter per output line; the active-high code selects which one counts.
   for (genvar k = 0; k < OUT_N; k++) begin : g_hit
      decoder_2to4_hitcnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .i_inc (w_dec[k]),
         .i_clr (hit_clr),
         .o_cnt (hit_cnt[k*CNT_W +: CNT_W])
      );
   end
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed bench for decoder_2to4: one active-high and one active-low instance
// share the same stimulus. Counter checks run when DECODER_2TO4_HITCNT_EN is set.
module tb_decoder_2to4;

   localparam int CW = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] inp;
   logic [3:0] outp_hi, outp_lo;
   logic       vld_hi, vld_lo;
`ifdef DECODER_2TO4_HITCNT_EN
   logic              hit_clr;
   logic [4*CW-1:0]   cnt_hi, cnt_lo;
   logic [7:0]        cnt_tab [5];
`endif
   logic [3:0] exp_tab [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(CW)) u_hi (
      .clk(clk), .rst(rst), .enable(enable), .inp(inp),
      .outp(outp_hi), .out_valid(vld_hi)
`ifdef DECODER_2TO4_HITCNT_EN
      , .hit_clr(hit_clr), .hit_cnt(cnt_hi)
`endif
   );

   decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1), .CNT_W(CW)) u_lo (
      .clk(clk), .rst(rst), .enable(enable), .inp(inp),
      .outp(outp_lo), .out_valid(vld_lo)
`ifdef DECODER_2TO4_HITCNT_EN
      , .hit_clr(hit_clr), .hit_cnt(cnt_lo)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // e is the active-high expectation; the low instance must show its inverse.
   task automatic chk_out(input string tag, input logic [3:0] e, input logic v);
      chk({tag, ".outp_hi"}, {28'd0, outp_hi}, {28'd0, e});
      chk({tag, ".outp_lo"}, {28'd0, outp_lo}, {28'd0, ~e});
      chk({tag, ".vld_hi"},  {31'd0, vld_hi},  {31'd0, v});
      chk({tag, ".vld_lo"},  {31'd0, vld_lo},  {31'd0, v});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_tab[0] = 4'b0001;
      exp_tab[1] = 4'b0010;
      exp_tab[2] = 4'b0100;
      exp_tab[3] = 4'b1000;
`ifdef DECODER_2TO4_HITCNT_EN
      cnt_tab[0] = 8'h10;
      cnt_tab[1] = 8'h20;
      cnt_tab[2] = 8'h30;
      cnt_tab[3] = 8'h30;
      cnt_tab[4] = 8'h30;
      hit_clr    = 1'b0;
`endif
      rst    = 1'b1;
      enable = 1'b0;
      inp    = 2'd0;

      // Reset and release between edges; nothing captured until the next edge.
      #12;
      rst = 1'b0;
      #1;
      chk_out("rst_init", 4'b0000, 1'b0);
      enable = 1'b1;
      inp    = 2'd2;
      tick();
      chk_out("first_cap", 4'b0100, 1'b1);

      // Async reset mid-cycle with enable=1, inp=2.
      #3;
      rst = 1'b1;
      #1;
      chk_out("rst_async", 4'b0000, 1'b0);
`ifdef DECODER_2TO4_HITCNT_EN
      chk("rst_async.cnt_hi", {24'd0, cnt_hi}, 32'd0);
`endif
      tick();
      chk_out("rst_hold", 4'b0000, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      chk_out("rst_release", 4'b0000, 1'b0);
      tick();
      chk_out("post_release", 4'b0100, 1'b1);

      // Sweep all select codes.
      for (int i = 0; i < 4; i++) begin
         inp = 2'(i);
         #1;
         if (i == 0) chk_out("sweep_pre", 4'b0100, 1'b1);
         tick();
         chk_out($sformatf("sweep%0d", i), exp_tab[i], 1'b1);
      end

      // Disable: lines drop at the next edge regardless of inp.
      enable = 1'b0;
      #1;
      chk_out("dis_pre", 4'b1000, 1'b1);
      tick();
      chk_out("dis0", 4'b0000, 1'b0);
      inp = 2'd1;
      tick();
      chk_out("dis1", 4'b0000, 1'b0);
      inp = 2'd2;
      tick();
      chk_out("dis2", 4'b0000, 1'b0);

      // Polarity: inp=1 enabled gives 1101 on the active-low instance.
      enable = 1'b1;
      inp    = 2'd1;
      tick();
      chk("pol_en.lo", {28'd0, outp_lo}, 32'h0000_000D);
      enable = 1'b0;
      tick();
      chk("pol_dis.lo", {28'd0, outp_lo}, 32'h0000_000F);

      // Multiple inp changes between edges; only the last is captured.
      enable = 1'b1;
      inp    = 2'd0;
      tick();
      chk_out("glitch_base", 4'b0001, 1'b1);
      #2;
      inp = 2'd3;
      #2;
      inp = 2'd1;
      #1;
      chk_out("glitch_mid", 4'b0001, 1'b1);
      tick();
      chk_out("glitch_edge", 4'b0010, 1'b1);

`ifdef DECODER_2TO4_HITCNT_EN
      hit_clr = 1'b1;
      tick();
      chk("cnt_clr0", {24'd0, cnt_hi}, 32'd0);
      hit_clr = 1'b0;
      enable  = 1'b1;
      inp     = 2'd2;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("cnt_sat%0d.hi", c), {24'd0, cnt_hi}, {24'd0, cnt_tab[c]});
         chk($sformatf("cnt_sat%0d.lo", c), {24'd0, cnt_lo}, {24'd0, cnt_tab[c]});
      end
      hit_clr = 1'b1;
      tick();
      chk("cnt_clr_pri", {24'd0, cnt_hi}, 32'd0);
      hit_clr = 1'b0;
      inp     = 2'd0;
      tick();
      chk("cnt_line0", {24'd0, cnt_hi}, 32'h0000_0001);
      inp = 2'd3;
      tick();
      chk("cnt_line3", {24'd0, cnt_hi}, 32'h0000_0041);
      enable = 1'b0;
      tick();
      chk("cnt_hold_dis", {24'd0, cnt_hi}, 32'h0000_0041);
      #3;
      rst = 1'b1;
      #1;
      chk("cnt_rst", {24'd0, cnt_hi}, 32'd0);
      rst = 1'b0;
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
